// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter: state encodings,
// the default timeout configuration and the data pattern returned to a
// master whose transaction is forcibly terminated.
package bus_arbiter_2m_pkg;

   // Arbiter state encodings (kept as plain constants for legacy tools)
   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_BUSY0 = 2'd1;
   localparam logic [1:0] ARB_BUSY1 = 2'd2;

   // Default timeout: cycles a granted transaction may wait for ready
   localparam int DEFAULT_TIMEOUT = 1024;
   // Default timeout counter width; 2**DEFAULT_TW must exceed DEFAULT_TIMEOUT
   localparam int DEFAULT_TW = 11;

   // Read data presented to a master whose transaction timed out
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter that watches a granted bus transaction and flags when it
// has waited TIMEOUT-1 cycles without the slave's ready. Only instantiated
// by bus_arbiter_2m when BUS_TIMEOUT_EN is defined.
module bus_timeout_counter #(
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TW-1:0] count;

   // Count waiting cycles; clear has priority and doubles as the reset path
   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TW'(1);
      end
   end

   assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master, single-slave round-robin arbiter for the CPU memory bus.
// A grant is held for the whole transaction until the slave's ready; one
// idle arbitration cycle separates consecutive slave transactions.
// Optional feature macro: BUS_TIMEOUT_EN -- forces termination (ready plus
// error, read data 0xDEADBEEF) of a transaction that waits TIMEOUT cycles.
module bus_arbiter_2m
   import bus_arbiter_2m_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TW      = DEFAULT_TW
) (
   input  logic        i_clock,
   input  logic        i_reset,
   // master 0
   input  logic        i_m0_request,
   input  logic        i_m0_rw,
   input  logic [31:0] i_m0_address,
   input  logic [31:0] i_m0_wdata,
   output logic [31:0] o_m0_rdata,
   output logic        o_m0_ready,
   output logic        o_m0_error,
   // master 1
   input  logic        i_m1_request,
   input  logic        i_m1_rw,
   input  logic [31:0] i_m1_address,
   input  logic [31:0] i_m1_wdata,
   output logic [31:0] o_m1_rdata,
   output logic        o_m1_ready,
   output logic        o_m1_error,
   // slave fabric
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_ready
);

   // Reject a counter too narrow to ever reach TIMEOUT-1
   if (TIMEOUT >= (1 << TW)) begin : g_tw_check
      $error("bus_arbiter_2m: TW too narrow for TIMEOUT");
   end

   logic [1:0] state;
   logic [1:0] state_next;
   logic       last_grant;
   logic       last_grant_next;
   logic       sel;              // master currently steering the bus mux
   logic       busy;
   logic       granted_request;
   logic       timeout;
   logic       finish;

   // Pick the master driving the bus: the owner when busy, else the next in turn
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sel = ~last_grant;
      case (state)
         ARB_BUSY0: sel = 1'b0;
         ARB_BUSY1: sel = 1'b1;
         default:   sel = ~last_grant;
      endcase
   end

   assign busy            = (state == ARB_BUSY0) || (state == ARB_BUSY1);
   assign granted_request = sel ? i_m1_request : i_m0_request;

   assign o_bus_rw      = sel ? i_m1_rw      : i_m0_rw;
   assign o_bus_address = sel ? i_m1_address : i_m0_address;
   assign o_bus_wdata   = sel ? i_m1_wdata   : i_m0_wdata;
   // Request is forced low while idle or in reset so arbitration costs a bus cycle
   assign o_bus_request = ~i_reset & busy & granted_request;

`ifdef BUS_TIMEOUT_EN
   logic expired;

   bus_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_timeout (
      .clock   (i_clock),
      .clear   (i_reset | ~busy),
      .enable  (busy & ~i_bus_ready),
      .expired (expired)
   );

   // A real ready in the expiry cycle wins, so timeout requires ready low
   assign timeout = ~i_reset & busy & expired & ~i_bus_ready;
`else
   assign timeout = 1'b0;
`endif

   // Completion (real or forced) is passed straight through to the owner
   assign finish = ~i_reset & busy & (i_bus_ready | timeout);

   assign o_m0_ready = finish  & (state == ARB_BUSY0);
   assign o_m1_ready = finish  & (state == ARB_BUSY1);
   assign o_m0_error = timeout & (state == ARB_BUSY0);
   assign o_m1_error = timeout & (state == ARB_BUSY1);
   assign o_m0_rdata = o_m0_error ? TIMEOUT_RDATA : i_bus_rdata;
   assign o_m1_rdata = o_m1_error ? TIMEOUT_RDATA : i_bus_rdata;

   // Round-robin grant from idle; leave busy on completion, timeout or abort
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         ARB_IDLE: begin
            if (i_m0_request && i_m1_request) begin
               state_next = last_grant ? ARB_BUSY0 : ARB_BUSY1;
            end else if (i_m0_request) begin
               state_next = ARB_BUSY0;
            end else if (i_m1_request) begin
               state_next = ARB_BUSY1;
            end
         end
         ARB_BUSY0, ARB_BUSY1: begin
            if (i_bus_ready || timeout) begin
               state_next      = ARB_IDLE;
               last_grant_next = (state == ARB_BUSY1);
            end else if (!granted_request) begin
               // Abort: the owner gave up without a ready, turn is not consumed
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // State register; reset drops any in-flight transaction and favours master 0
   always_ff @(posedge i_clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_reset) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: directed scenarios followed by
// randomized masters/slave, all checked every cycle against a
// transaction-level reference model. Honours BUS_TIMEOUT_EN.
module tb_bus_arbiter_2m;

   localparam int TB_TIMEOUT = 8;
   localparam int TB_TW      = 4;
`ifdef BUS_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   typedef enum int {M_MANUAL, M_CONT, M_RAND} mmode_t;
   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;
   typedef struct {
      int          m;
      logic [31:0] rdata;
      logic        err;
      int          run;   // cycles o_bus_request was high for this transaction
      int          gap;   // request-low cycles preceding it
   } done_t;

   logic        clock;
   logic        i_reset;
   logic [31:0] o_m0_rdata, o_m1_rdata;
   logic        o_m0_ready, o_m1_ready, o_m0_error, o_m1_error;
   logic        o_bus_request, o_bus_rw;
   logic [31:0] o_bus_address, o_bus_wdata;
   logic [31:0] i_bus_rdata;
   logic        i_bus_ready;

   logic        m_req   [2];
   logic        m_rw    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];

   bus_arbiter_2m #(.TIMEOUT(TB_TIMEOUT), .TW(TB_TW)) dut (
      .i_clock       (clock),
      .i_reset       (i_reset),
      .i_m0_request  (m_req[0]),
      .i_m0_rw       (m_rw[0]),
      .i_m0_address  (m_addr[0]),
      .i_m0_wdata    (m_wdata[0]),
      .o_m0_rdata    (o_m0_rdata),
      .o_m0_ready    (o_m0_ready),
      .o_m0_error    (o_m0_error),
      .i_m1_request  (m_req[1]),
      .i_m1_rw       (m_rw[1]),
      .i_m1_address  (m_addr[1]),
      .i_m1_wdata    (m_wdata[1]),
      .o_m1_rdata    (o_m1_rdata),
      .o_m1_ready    (o_m1_ready),
      .o_m1_error    (o_m1_error),
      .o_bus_request (o_bus_request),
      .o_bus_rw      (o_bus_rw),
      .o_bus_address (o_bus_address),
      .o_bus_wdata   (o_bus_wdata),
      .i_bus_rdata   (i_bus_rdata),
      .i_bus_ready   (i_bus_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", tag, actual, expected, $time);
      end
   endtask

   // ---------------- stimulus state ----------------
   mmode_t      mode [2];
   txn_t        man_txn [2];
   bit          man_go [2];
   bit          done [2];
   bit          drop_all;
   bit          rst_req;
   bit          slave_rand;
   int          slave_lat;
   int          slave_cnt;
   bit          force_ready;
   logic [31:0] slave_rdata;
   bit          chk_en;
   done_t       log_q[$];

   // ---------------- reference model state ----------------
   int          own;      // granted master, -1 when nobody holds the bus
   int          lastg;    // master that last completed
   int          busy_n;   // ordinal of the current granted cycle
   int          hi_run, lo_run, gap_cur;
   int          sel_m;
   bit          to_now, exp_breq, own_req;
   bit          exp_rdy [2];
   bit          exp_err [2];

   task automatic new_txn(input int n);
      m_req[n]   = 1'b1;
      m_rw[n]    = 1'($urandom_range(1, 0));
      m_addr[n]  = $urandom;
      m_wdata[n] = $urandom;
   endtask

   task automatic update_masters();
      for (int n = 0; n < 2; n++) begin
         if (drop_all) begin
            m_req[n] = 1'b0;
         end else if (m_req[n] && done[n]) begin
            m_req[n] = 1'b0;
            if (mode[n] == M_CONT || (mode[n] == M_RAND && $urandom_range(1, 0) == 1)) new_txn(n);
         end else if (m_req[n] && mode[n] == M_RAND && $urandom_range(49, 0) == 0) begin
            m_req[n] = 1'b0;
         end else if (!m_req[n] && (mode[n] == M_CONT ||
                                    (mode[n] == M_RAND && $urandom_range(2, 0) == 0))) begin
            new_txn(n);
         end
         if (mode[n] == M_MANUAL && man_go[n]) begin
            m_req[n]   = 1'b1;
            m_rw[n]    = man_txn[n].rw;
            m_addr[n]  = man_txn[n].addr;
            m_wdata[n] = man_txn[n].wdata;
            man_go[n]  = 1'b0;
         end
         done[n] = 1'b0;
      end
   endtask

   task automatic update_slave();
      if (slave_rand) begin
         i_bus_ready = ($urandom_range(9, 0) < 3);
         i_bus_rdata = $urandom;
      end else begin
         if (o_bus_request) slave_cnt++;
         else slave_cnt = 0;
         i_bus_ready = force_ready ||
                       (slave_lat >= 0 && o_bus_request && slave_cnt == slave_lat + 1);
         i_bus_rdata = slave_rdata;
         if (i_bus_ready) slave_cnt = 0;
      end
   endtask

   // Advance to the next cycle and set up all of its inputs
   task automatic cycle();
      @(posedge clock);
      #1;
      i_reset = rst_req;
      update_masters();
      #1;
      update_slave();
   endtask

   task automatic reset_all();
      rst_req  = 1'b1;
      drop_all = 1'b1;
      cycle();
      drop_all = 1'b0;
      rst_req  = 1'b0;
      log_q.delete();
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         cycle();
         k++;
      end
      if (log_q.size() < n) check(tag, 32'(log_q.size()), 32'(n));
   endtask

   // Per-cycle comparison against the reference model, then model advance
   always @(negedge clock) begin
      if (chk_en) begin
         sel_m    = (own >= 0) ? own : 1 - lastg;
         own_req  = (own == 0) ? m_req[0] : (own == 1) ? m_req[1] : 1'b0;
         exp_breq = !i_reset && own >= 0 && own_req;
         to_now   = TO_ON && !i_reset && own >= 0 && !i_bus_ready && busy_n == TB_TIMEOUT;
         for (int n = 0; n < 2; n++) begin
            exp_rdy[n] = !i_reset && own == n && (i_bus_ready || to_now);
            exp_err[n] = !i_reset && own == n && to_now;
         end
         check("bus_request", 32'(o_bus_request), 32'(exp_breq));
         check("bus_rw",      32'(o_bus_rw),      32'(m_rw[sel_m]));
         check("bus_address", o_bus_address,      m_addr[sel_m]);
         check("bus_wdata",   o_bus_wdata,        m_wdata[sel_m]);
         check("m0_ready",    32'(o_m0_ready),    32'(exp_rdy[0]));
         check("m1_ready",    32'(o_m1_ready),    32'(exp_rdy[1]));
         check("m0_error",    32'(o_m0_error),    32'(exp_err[0]));
         check("m1_error",    32'(o_m1_error),    32'(exp_err[1]));
         check("m0_rdata",    o_m0_rdata, exp_err[0] ? 32'hDEADBEEF : i_bus_rdata);
         check("m1_rdata",    o_m1_rdata, exp_err[1] ? 32'hDEADBEEF : i_bus_rdata);

         if (o_bus_request) begin
            if (hi_run == 0) gap_cur = lo_run;
            hi_run++;
            lo_run = 0;
         end else begin
            hi_run = 0;
            lo_run++;
         end
         if (o_m0_ready) log_q.push_back('{0, o_m0_rdata, o_m0_error, hi_run, gap_cur});
         if (o_m1_ready) log_q.push_back('{1, o_m1_rdata, o_m1_error, hi_run, gap_cur});
         done[0] = o_m0_ready;
         done[1] = o_m1_ready;

         if (i_reset) begin
            own   = -1;
            lastg = 1;
         end else if (own < 0) begin
            if (m_req[0] && m_req[1]) own = 1 - lastg;
            else if (m_req[0]) own = 0;
            else if (m_req[1]) own = 1;
            busy_n = 1;
         end else if (i_bus_ready || to_now) begin
            lastg = own;
            own   = -1;
         end else if (!own_req) begin
            own = -1;
         end else begin
            busy_n++;
         end
      end
   end

   initial begin
      own = -1; lastg = 1; busy_n = 0;
      hi_run = 0; lo_run = 0; gap_cur = 0;
      chk_en = 1'b0; drop_all = 1'b0; force_ready = 1'b0;
      slave_rand = 1'b0; slave_lat = 2; slave_cnt = 0; slave_rdata = 32'h0;
      i_reset = 1'b1; i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
      for (int n = 0; n < 2; n++) begin
         mode[n] = M_MANUAL; man_go[n] = 1'b0; done[n] = 1'b0;
         m_req[n] = 1'b0; m_rw[n] = 1'b0; m_addr[n] = 32'h0; m_wdata[n] = 32'h0;
      end

      // Reset held 3 cycles with m0 requesting; first grant one cycle after release
      rst_req = 1'b1;
      man_txn[0] = '{1'b0, 32'h0000_0010, 32'h0};
      man_go[0]  = 1'b1;
      slave_rdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_en = 1'b1;
         check("reset_bus_request", 32'(o_bus_request), 32'd0);
      end
      rst_req = 1'b0;
      log_q.delete();
      cycle();
      check("arb_cycle_request", 32'(o_bus_request), 32'd0);
      cycle();
      check("first_grant_request", 32'(o_bus_request), 32'd1);
      check("first_grant_address", o_bus_address, 32'h0000_0010);
      wait_log(1, 20, "m0_read_timeout");
      if (log_q.size() >= 1) begin
         check("m0_read_master", 32'(log_q[0].m), 32'd0);
         check("m0_read_rdata",  log_q[0].rdata, 32'h1234_5678);
         check("m0_read_latency", 32'(log_q[0].run), 32'd3);
      end

      // Both masters continuously: strict alternation, one idle cycle between
      reset_all();
      mode[0] = M_CONT;
      mode[1] = M_CONT;
      wait_log(6, 100, "rr_timeout");
      for (int i = 0; i < 6; i++) begin
         if (i < log_q.size()) begin
            check($sformatf("rr_order%0d", i), 32'(log_q[i].m), 32'(i % 2));
            if (i > 0) check($sformatf("rr_gap%0d", i), 32'(log_q[i].gap), 32'd1);
         end
      end
      mode[0] = M_MANUAL;
      mode[1] = M_MANUAL;

      // m1 write held on the bus while m0 requests mid-transaction
      reset_all();
      slave_lat  = 3;
      man_txn[1] = '{1'b1, 32'h0001_0004, 32'hCAFE_F00D};
      man_go[1]  = 1'b1;
      cycle();
      cycle();
      man_txn[0] = '{1'b0, 32'h0000_0020, 32'h0};
      man_go[0]  = 1'b1;
      cycle();
      check("m1_write_address", o_bus_address, 32'h0001_0004);
      check("m1_write_wdata",   o_bus_wdata,   32'hCAFE_F00D);
      check("m1_write_rw",      32'(o_bus_rw), 32'd1);
      wait_log(2, 40, "m1_write_timeout");
      if (log_q.size() >= 2) begin
         check("m1_write_first", 32'(log_q[0].m), 32'd1);
         check("m0_after_m1",    32'(log_q[1].m), 32'd0);
         check("m0_after_gap",   32'(log_q[1].gap), 32'd1);
      end

      // Reset while BUSY1 drops the transaction; late ready ignored
      reset_all();
      slave_lat  = -1;
      man_txn[1] = '{1'b0, 32'h0000_0030, 32'h0};
      man_go[1]  = 1'b1;
      cycle();
      cycle();
      cycle();
      check("busy1_request", 32'(o_bus_request), 32'd1);
      rst_req     = 1'b1;
      force_ready = 1'b1;
      cycle();
      check("midrst_request", 32'(o_bus_request), 32'd0);
      check("midrst_m1_ready", 32'(o_m1_ready), 32'd0);
      rst_req = 1'b0;
      cycle();
      check("late_ready_request", 32'(o_bus_request), 32'd0);
      check("late_ready_m1", 32'(o_m1_ready), 32'd0);
      force_ready = 1'b0;
      cycle();
      check("regrant_m1_request", 32'(o_bus_request), 32'd1);
      check("no_ready_after_reset", 32'(log_q.size()), 32'd0);
      slave_lat = 1;
      wait_log(1, 20, "regrant_timeout");
      if (log_q.size() >= 1) check("regrant_master", 32'(log_q[0].m), 32'd1);

`ifdef BUS_TIMEOUT_EN
      // Slave never readies: forced termination on the TIMEOUT-th busy cycle
      reset_all();
      slave_lat  = -1;
      man_txn[0] = '{1'b0, 32'h0000_0040, 32'h0};
      man_txn[1] = '{1'b0, 32'h0000_0050, 32'h0};
      man_go[0]  = 1'b1;
      man_go[1]  = 1'b1;
      wait_log(1, 40, "timeout_wait");
      if (log_q.size() >= 1) begin
         check("timeout_master", 32'(log_q[0].m), 32'd0);
         check("timeout_error",  32'(log_q[0].err), 32'd1);
         check("timeout_rdata",  log_q[0].rdata, 32'hDEADBEEF);
         check("timeout_cycle",  32'(log_q[0].run), 32'(TB_TIMEOUT));
      end
      slave_lat = 1;
      wait_log(2, 20, "post_timeout_wait");
      if (log_q.size() >= 2) begin
         check("post_timeout_master", 32'(log_q[1].m), 32'd1);
         check("post_timeout_error",  32'(log_q[1].err), 32'd0);
      end
`endif

      // Randomized traffic with occasional resets, checked by the model
      reset_all();
      mode[0]    = M_RAND;
      mode[1]    = M_RAND;
      slave_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst_req = ($urandom_range(199, 0) == 0);
         cycle();
      end
      check("rand_activity", 32'(log_q.size() > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master, single-slave arbiter for the CPU memory bus (request/ready/rw/address/wdata/rdata).
- Lets a second master (e.g. DMA or debug port) share the ROM/RAM bus with the CPU.
- Sits between the masters and the address-decode fabric.
- Round-robin grant; a grant is held for the whole transaction until the slave's ready.

Parameters:
- TIMEOUT, 1024: cycles a granted transaction may wait for ready before forced termination (used only with BUS_TIMEOUT_EN).
- TW, 11: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- i_clock  in  1  system clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_request  in  1  master 0 request; held high until its ready.
- i_m0_rw  in  1  master 0 direction, 1 = write.
- i_m0_address  in  32  master 0 byte address.
- i_m0_wdata  in  32  master 0 write data.
- o_m0_rdata  out  32  master 0 read data.
- o_m0_ready  out  1  master 0 completion strobe (one cycle).
- o_m0_error  out  1  master 0 timeout strobe, coincident with o_m0_ready.
- i_m1_request, i_m1_rw, i_m1_address, i_m1_wdata, o_m1_rdata, o_m1_ready, o_m1_error: same as master 0, for master 1.
- o_bus_request  out  1  request to slave fabric.
- o_bus_rw  out  1  forwarded direction.
- o_bus_address  out  32  forwarded address.
- o_bus_wdata  out  32  forwarded write data.
- i_bus_rdata  in  32  slave read data.
- i_bus_ready  in  1  slave completion strobe.

Behaviour:
- Registered state: state ∈ {IDLE, BUSY0, BUSY1}; last_grant (1 bit).
- Reset (any cycle, including mid-transaction):
  - state = IDLE, last_grant = 1, so master 0 wins the first tie.
  - o_bus_request = 0; all ready/error outputs = 0.
  - Any in-flight transaction is dropped without a ready to either master.
- IDLE:
  - Only one master requesting: go to that master's BUSY state.
  - Both requesting: grant master !last_grant.
  - o_bus_request = 0 in IDLE, so arbitration costs exactly one cycle and guarantees at least one request-low cycle between slave transactions.
- BUSY_n, forwarding:
  - o_bus_request = i_mn_request; o_bus_rw/address/wdata are driven from master n (combinational mux).
  - In IDLE, the bus address/wdata/rw mux selects master !last_grant; request is 0.
- BUSY_n, completion (i_bus_ready = 1):
  - o_mn_ready = 1 in the same cycle (combinational pass-through).
  - Next state: IDLE, last_grant = n.
- BUSY_n, abort: master n drops its request without ready -> IDLE, last_grant unchanged.
- Slave ready while IDLE is ignored; no master sees it.
- Read data: o_m0_rdata = o_m1_rdata = i_bus_rdata at all times. Masters qualify it with their own ready.
- Non-granted master: ready and error are always 0; its request is simply held pending.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1. Maximum wait is one foreign transaction plus 2 cycles.
- Ready strobe and a new request from the other master in the same cycle: completion wins; the other master is granted from IDLE next cycle.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - A TW-bit counter clears on entry to BUSY_n and increments each BUSY cycle without ready.
  - When the count reaches TIMEOUT-1 and ready is still low: o_mn_ready = 1, o_mn_error = 1, o_mn_rdata = 32'hDEADBEEF; state -> IDLE; last_grant = n.
  - A real ready arriving in that same cycle takes precedence, with error = 0.
- Without the macro: no counter; BUSY waits indefinitely; o_m0_error and o_m1_error are tied to 0.

Decomposition:
- Shared package/header holds:
  - State encodings: ARB_IDLE = 2'd0, ARB_BUSY0 = 2'd1, ARB_BUSY1 = 2'd2.
  - Default TIMEOUT.
  - Timeout read pattern 32'hDEADBEEF.
- Sub-module bus_timeout_counter (clear, enable, expired) is instantiated only under BUS_TIMEOUT_EN; everything else stays in a single module.

Test Plan:
- Reset held 3 cycles while m0 requests -> o_bus_request = 0 throughout; first grant goes to m0 one cycle after reset release.
- m0 reads 0x00000010, slave gives ready 2 cycles after o_bus_request with rdata 0x12345678 -> o_m0_ready for 1 cycle with o_m0_rdata = 0x12345678; o_m1_ready stays 0.
- Both masters request continuously for 6 transactions -> grant order 0,1,0,1,0,1; o_bus_request low exactly 1 cycle between transactions.
- m1 writes 0x00010004 / 0xCAFEF00D while m0 requests mid-transaction -> bus holds m1's address/wdata until ready; m0 is granted next.
- Reset asserted while in BUSY1 -> next cycle state IDLE, o_bus_request = 0, no ready to m1; a late i_bus_ready is ignored.
- BUS_TIMEOUT_EN, TIMEOUT = 8, slave never readies -> o_m0_ready = o_m0_error = 1 on the 8th BUSY cycle with rdata 0xDEADBEEF; then m1 is granted.
